ex: RTL and testbench
=====================

// Module: ex
// PURPOSE
//   Execute stage of the RV32 pipeline. Consumes the id_ex register outputs and produces the
//   write-back triple (rd_addr_o, rd_data_o, reg_wen_o).
//   - RV32I OP/OP-IMM/LUI: one cycle, combinational.
//   - RV32M DIV/DIVU/REM/REMU: iterative, 1 quotient bit per cycle. Upstream is frozen via hold_o.
// PARAMETERS
//   XLEN   32   datapath width; only 32 is supported
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous, active-low reset
//   inst_i       in   32  instruction from id_ex (bubble = 32'h00000013)
//   inst_addr_i  in   32  PC of inst_i; passed through, unused by arithmetic
//   op_num1_i    in   32  operand 1 (rs1 value, or 0 for LUI)
//   op_num2_i    in   32  operand 2 (rs2 value or sign-extended immediate)
//   rd_addr_i    in   5   destination register
//   reg_wen_i    in   1   destination write request from decode
//   flush_i      in   1   kill the in-flight instruction (branch redirect / trap)
//   rd_addr_o    out  5   write-back address
//   rd_data_o    out  32  write-back data
//   reg_wen_o    out  1   write-back enable
//   hold_o       out  1   stall request to pc/if_id/id_ex: hold current contents
// BEHAVIOUR
//   Reset (rst=0): FSM -> IDLE, counter/accumulators cleared. reg_wen_o=0, hold_o=0, rd_data_o=0, rd_addr_o=0.
//   Single-cycle ops (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, immediate forms, LUI):
//     rd_data_o = f(op_num1_i, op_num2_i) in the same cycle; reg_wen_o = reg_wen_i; hold_o = 0.
//     Shift amount = op_num2_i[4:0].
//   Unrecognised encodings: reg_wen_o = 0; no hold.
//   FSM IDLE -> BUSY -> DONE -> IDLE (multi-cycle ops only):
//     IDLE, M-op decoded, not special:
//       - hold_o=1, reg_wen_o=0.
//       - Latch |op1|, |op2|, sign info, rd, funct3. Count=0. -> BUSY.
//     BUSY: one restoring-divide step per cycle; hold_o=1, reg_wen_o=0. After 32 steps -> DONE.
//     DONE:
//       - Sign-corrected result on rd_data_o; reg_wen_o = latched reg_wen; hold_o = 0.
//       - Next edge -> IDLE; id_ex advances on that same edge.
//     Latency: 34 cycles from presentation to write-back.
//   Signs:
//     - Quotient is negated when the operand signs differ (signed ops only).
//     - Remainder takes the sign of the dividend.
//   Special cases (detected in IDLE; single-cycle result, no hold):
//     - Divisor 0: quotient = 32'hFFFFFFFF, remainder = op_num1_i.
//     - Signed 32'h80000000 / 32'hFFFFFFFF: quotient = 32'h80000000, remainder = 0.
//   rd == x0: the op still runs its full latency and hold. reg_wen_o passes through;
//     the register file ignores writes to x0.
//   flush_i:
//     - In BUSY/DONE: -> IDLE next edge, no write-back, hold_o drops in that cycle.
//     - In IDLE: reg_wen_o forced 0 and no new operation starts.
//   Reset mid-operation: immediate abort to IDLE; no write-back.
// CONFIGURATION
//   EX_FAST_MUL_EN defined:
//     MUL/MULH/MULHSU/MULHU are single-cycle, using a combinational 33x33 signed product
//     (operand sign extension per funct3). No hold.
//   EX_FAST_MUL_EN undefined:
//     MUL* use the iterative engine as shift-add: 32 steps, 64-bit accumulator,
//     same FSM/latency/hold as DIV.
//     Signed forms multiply magnitudes, then negate the 64-bit product when the signs differ.
//     MUL returns the low word; MULH/MULHSU/MULHU return the high word.
// STRUCTURE
//   Shared defines header ex_defs.vh:
//     - Opcodes: OP, OP_IMM, LUI.
//     - funct3 codes.
//     - FUNCT7_M = 7'b0000001.
//     - INST_NOP = 32'h00000013.
//     - FSM state encodings.
//   Sub-module ex_muldiv_iter:
//     - Contains the FSM, counter, and divide (plus optional multiply) datapath.
//     - start/op/operands in; result/busy/done out.
//     - ex holds decode, ALU and output muxing.
// TESTING
//   1 ADD op1=5, op2=-3 (funct7=0) -> same cycle rd_data_o=2, reg_wen_o=1, hold_o=0.
//   2 DIV op1=-7, op2=2 -> hold_o high for 33 cycles; cycle 34: rd_data_o=-3 (32'hFFFFFFFD),
//     reg_wen_o=1. REM with the same operands -> -1.
//   3 DIVU op1=100, op2=0 -> same cycle 32'hFFFFFFFF, no hold.
//     REM op1=32'h80000000, op2=-1 -> 0, no hold.
//   4 DIVU issued, flush_i pulsed at BUSY count 10 -> IDLE next edge; reg_wen_o never asserted;
//     next ADD completes normally.
//   5 rst dropped at BUSY count 20 -> all outputs 0 immediately; after release, IDLE accepts a new DIV.
//   6 MULH op1=32'h80000000, op2=2 -> 32'hFFFFFFFF.
//     Fast build: single cycle. Iterative build: 34-cycle latency with hold.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: opcodes, funct codes and state encodings shared by the
// execute stage and its iterative mul/div engine.
package ex_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] FUNCT7_0   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;
  localparam logic [6:0] FUNCT7_M   = 7'b0000001;

  localparam logic [31:0] INST_NOP = 32'h00000013;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // {op1 signed, op2 signed} for each M-extension funct3
  function automatic logic [1:0] md_signs(input logic [2:0] f3);
    md_signs = 2'b00;
    unique case (f3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: md_signs = 2'b11;
      F3_MULHSU:                       md_signs = 2'b10;
      F3_MULHU, F3_DIVU, F3_REMU:      md_signs = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: radix-2 iterative engine, restoring divide and
// shift-add multiply on operand magnitudes, sign fixed up in DONE.
module ex_muldiv_iter
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_i,
  input  logic            wen_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            wen_o
);

  md_state_e       state_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] r_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic            rneg_q;
  logic [4:0]      rd_q;
  logic            wen_q;

  logic [1:0]      sg;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN:0]   rsh;
  logic [XLEN:0]   diff;
  logic [XLEN:0]   sum;

  assign sg    = md_signs(op_i);
  assign sa    = sg[1] & op1_i[XLEN-1];
  assign sb    = sg[0] & op2_i[XLEN-1];
  assign a_abs = sa ? -op1_i : op1_i;
  assign b_abs = sb ? -op2_i : op2_i;

  assign rsh  = {r_q, a_q[XLEN-1]};
  assign diff = rsh - {1'b0, b_q};
  assign sum  = {1'b0, r_q} + (a_q[0] ? {1'b0, b_q} : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start_i && !flush_i) begin
            state_q <= MD_BUSY;
            cnt_q   <= '0;
            a_q     <= a_abs;
            b_q     <= b_abs;
            r_q     <= '0;
            op_q    <= op_i;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            rd_q    <= rd_i;
            wen_q   <= wen_i;
          end
        end
        MD_BUSY: begin
          if (flush_i) begin
            state_q <= MD_IDLE;
          end else begin
            if (!op_q[2]) begin
              r_q <= sum[XLEN:1];
              a_q <= {sum[0], a_q[XLEN-1:1]};
            end else begin
              r_q <= diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0];
              a_q <= {a_q[XLEN-2:0], ~diff[XLEN]};
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= MD_DONE;
          end
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  assign prod   = {r_q, a_q};
  assign prod_c = neg_q ? -prod : prod;
  assign quo    = neg_q ? -a_q : a_q;
  assign rem    = rneg_q ? -r_q : r_q;

  always_comb begin
    result_o = quo;
    unique case (1'b1)
      op_q == F3_MUL:             result_o = prod_c[XLEN-1:0];
      !op_q[2] && op_q != F3_MUL: result_o = prod_c[2*XLEN-1:XLEN];
      op_q[2] && op_q[1]:         result_o = rem;
      op_q[2] && !op_q[1]:        result_o = quo;
      default:                    result_o = quo;
    endcase
  end

  assign busy_o = state_q == MD_BUSY;
  assign done_o = state_q == MD_DONE;
  assign rd_o   = rd_q;
  assign wen_o  = wen_q;

endmodule

// File: rtl/ex.sv
// ex: RV32IM execute stage, single-cycle ALU plus iterative mul/div.
// Define EX_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op_num1_i,
  input  logic [XLEN-1:0] op_num2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,
  input  logic            flush_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            reg_wen_o,
  output logic            hold_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign unused_bits = ^{inst_addr_i, inst_i[24:15], inst_i[11:7]};

  logic    legal;
  logic    alt;
  logic    is_md;
  logic    is_nop;
  alu_op_e alu_op;

  assign is_nop = inst_i == INST_NOP;

  always_comb begin
    legal = 1'b0;
    alt   = 1'b0;
    is_md = 1'b0;
    unique case (1'b1)
      opcode == OPC_LUI: legal = 1'b1;
      opcode == OPC_OP: begin
        is_md = funct7 == FUNCT7_M;
        alt   = funct7 == FUNCT7_ALT;
        legal = funct7 == FUNCT7_0 ||
                (alt && (funct3 == F3_ADD || funct3 == F3_SR));
      end
      opcode == OPC_OP_IMM: begin
        alt   = funct3 == F3_SR && funct7 == FUNCT7_ALT;
        legal = funct3 == F3_SLL ? funct7 == FUNCT7_0 :
                funct3 == F3_SR  ? (funct7 == FUNCT7_0 || alt) :
                1'b1;
      end
      default: ;
    endcase
  end

  // LUI carries immediate bits in funct3, so it bypasses the map
  always_comb begin
    alu_op = ALU_ADD;
    if (opcode != OPC_LUI) begin
      unique case (funct3)
        F3_ADD:  alu_op = alt ? ALU_SUB : ALU_ADD;
        F3_SLL:  alu_op = ALU_SLL;
        F3_SLT:  alu_op = ALU_SLT;
        F3_SLTU: alu_op = ALU_SLTU;
        F3_XOR:  alu_op = ALU_XOR;
        F3_SR:   alu_op = alt ? ALU_SRA : ALU_SRL;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
      endcase
    end
  end

  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;

  assign shamt = op_num2_i[4:0];

  always_comb begin
    unique case (alu_op)
      ALU_ADD:  alu_res = op_num1_i + op_num2_i;
      ALU_SUB:  alu_res = op_num1_i - op_num2_i;
      ALU_SLL:  alu_res = op_num1_i << shamt;
      ALU_SLT:  alu_res = {31'd0, $signed(op_num1_i) < $signed(op_num2_i)};
      ALU_SLTU: alu_res = {31'd0, op_num1_i < op_num2_i};
      ALU_XOR:  alu_res = op_num1_i ^ op_num2_i;
      ALU_SRL:  alu_res = op_num1_i >> shamt;
      ALU_SRA:  alu_res = $signed(op_num1_i) >>> shamt;
      ALU_OR:   alu_res = op_num1_i | op_num2_i;
      ALU_AND:  alu_res = op_num1_i & op_num2_i;
      default:  alu_res = '0;
    endcase
  end

  logic            div0;
  logic            ovf;
  logic            md_special;
  logic [XLEN-1:0] spec_res;

  assign div0 = op_num2_i == '0;
  assign ovf  = !funct3[0] && op_num1_i == 32'h80000000 &&
                op_num2_i == '1;
  assign md_special = funct3[2] && (div0 || ovf);
  assign spec_res = div0 ? (funct3[1] ? op_num1_i : '1) :
                           (funct3[1] ? '0 : 32'h80000000);

  logic            fast_mul;
  logic [XLEN-1:0] fast_res;

`ifdef EX_FAST_MUL_EN
  logic [1:0]         fsg;
  logic signed [32:0] fa;
  logic signed [32:0] fb;
  logic signed [65:0] fprod;
  logic               unused_fast;

  assign fsg      = md_signs(funct3);
  assign fa       = {fsg[1] & op_num1_i[XLEN-1], op_num1_i};
  assign fb       = {fsg[0] & op_num2_i[XLEN-1], op_num2_i};
  assign fprod    = fa * fb;
  assign fast_mul = !funct3[2];
  assign fast_res = funct3 == F3_MUL ? fprod[31:0] : fprod[63:32];
  assign unused_fast = ^fprod[65:64];
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  logic            md_iter;
  logic            md_start;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_res;
  logic [4:0]      md_rd;
  logic            md_wen;

  assign md_iter  = is_md && !fast_mul && !md_special;
  assign md_start = md_iter && !md_busy && !md_done && !flush_i;

  ex_muldiv_iter u_md (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .flush_i  (flush_i),
    .op_i     (funct3),
    .op1_i    (op_num1_i),
    .op2_i    (op_num2_i),
    .rd_i     (rd_addr_i),
    .wen_i    (reg_wen_i),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res),
    .rd_o     (md_rd),
    .wen_o    (md_wen)
  );

  always_comb begin
    rd_addr_o = rd_addr_i;
    rd_data_o = '0;
    reg_wen_o = 1'b0;
    hold_o    = 1'b0;
    if (!rst) begin
      rd_addr_o = '0;
    end else if (md_done) begin
      rd_addr_o = md_rd;
      rd_data_o = md_res;
      reg_wen_o = md_wen && !flush_i;
    end else if (md_busy) begin
      rd_addr_o = md_rd;
      hold_o    = !flush_i;
    end else if (md_iter) begin
      hold_o    = !flush_i;
    end else if (is_md) begin
      rd_data_o = md_special ? spec_res : fast_res;
      reg_wen_o = reg_wen_i && !flush_i;
    end else if (legal) begin
      rd_data_o = alu_res;
      reg_wen_o = reg_wen_i && !flush_i && !is_nop;
    end
  end

endmodule

// File: tb/tb_ex.sv
// tb_ex: directed scoreboard bench for the execute stage.
// Expected results come from an arithmetic reference model.
module tb_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  rd_in;
  logic        wen_in;
  logic        flush;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        reg_wen_o;
  logic        hold_o;

  always #5 clk = ~clk;

  ex dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst),
    .inst_addr_i (pc),
    .op_num1_i   (op1),
    .op_num2_i   (op2),
    .rd_addr_i   (rd_in),
    .reg_wen_i   (wen_in),
    .flush_i     (flush),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .reg_wen_o   (reg_wen_o),
    .hold_o      (hold_o)
  );

`ifdef EX_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7,
                                        input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm,
                                        input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    logic        ov;
    ov = a == 32'h80000000 && b == 32'hFFFFFFFF;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[63:32];
      end
      3'd2: begin
        p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
        return p[63:32];
      end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFFFFFF : ov ? a :
                   32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : ov ? 32'd0 :
                   32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic issue(input string tag, input logic [31:0] in,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expd,
                       input int lat);
    exp_t e;
    int   n;
    int   holds;
    int   early;
    inst   = in;
    op1    = a;
    op2    = b;
    rd_in  = rd;
    wen_in = 1'b1;
    sb.push_back({1'b1, rd, expd, 8'(lat)});
    n = 0;
    holds = 0;
    early = 0;
    do begin
      @(negedge clk);
      n++;
      if (hold_o) holds++;
      if (hold_o && reg_wen_o) early++;
    end while (hold_o && n < 60);
    e = sb.pop_front();
    chk({tag, ":lat"}, 32'(n), 32'(e.lat));
    chk({tag, ":hold"}, 32'(holds), 32'(e.lat) - 32'd1);
    chk({tag, ":early"}, 32'(early), 32'd0);
    chk({tag, ":data"}, rd_data_o, e.data);
    chk({tag, ":wen"}, {31'd0, reg_wen_o}, {31'd0, e.wen});
    chk({tag, ":addr"}, {27'd0, rd_addr_o}, {27'd0, e.addr});
    @(posedge clk);
    #1;
  endtask

  logic [31:0] i_add;
  logic [31:0] i_div;
  logic [31:0] i_divu;
  logic [31:0] i_rem;
  logic [31:0] i_remu;
  int          seen;
  int          hseen;

  initial begin
    i_add  = rtype(7'b0000000, 3'b000, 5'd3);
    i_div  = rtype(7'b0000001, 3'b100, 5'd4);
    i_divu = rtype(7'b0000001, 3'b101, 5'd5);
    i_rem  = rtype(7'b0000001, 3'b110, 5'd6);
    i_remu = rtype(7'b0000001, 3'b111, 5'd7);
    pc     = 32'h0000_1000;
    flush  = 1'b0;
    rst    = 1'b0;
    inst   = i_add;
    op1    = 32'd5;
    op2    = 32'd9;
    rd_in  = 5'd3;
    wen_in = 1'b1;
    #12;
    chk("rst:data", rd_data_o, 32'd0);
    chk("rst:wen", {31'd0, reg_wen_o}, 32'd0);
    chk("rst:hold", {31'd0, hold_o}, 32'd0);
    chk("rst:addr", {27'd0, rd_addr_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    issue("add", i_add, 32'd5, -32'sd3, 5'd3, 32'd2, 1);
    issue("sub", rtype(7'b0100000, 3'b000, 5'd8), 32'd5, -32'sd3,
          5'd8, 32'd8, 1);
    issue("srai", itype(12'h404, 3'b101, 5'd9), 32'h80000000,
          32'h00000404, 5'd9, 32'hF8000000, 1);
    issue("sltu", rtype(7'b0000000, 3'b011, 5'd10), 32'd1,
          32'hFFFFFFFF, 5'd10, 32'd1, 1);
    issue("slt", rtype(7'b0000000, 3'b010, 5'd11), 32'd1,
          32'hFFFFFFFF, 5'd11, 32'd0, 1);
    issue("lui", {20'h12345, 5'd12, 7'b0110111}, 32'd0,
          32'h12345000, 5'd12, 32'h12345000, 1);

    issue("div", i_div, -32'sd7, 32'd2, 5'd4, 32'hFFFFFFFD, 34);
    issue("rem", i_rem, -32'sd7, 32'd2, 5'd6, 32'hFFFFFFFF, 34);
    issue("divu", i_divu, 32'hFFFFFFFF, 32'd3, 5'd5,
          ref_md(3'd5, 32'hFFFFFFFF, 32'd3), 34);
    issue("remu", i_remu, 32'd1000, 32'd7, 5'd7,
          ref_md(3'd7, 32'd1000, 32'd7), 34);
    issue("divx0", rtype(7'b0000001, 3'b100, 5'd0), 32'd50,
          -32'sd6, 5'd0, ref_md(3'd4, 32'd50, -32'sd6), 34);

    issue("divu0", i_divu, 32'd100, 32'd0, 5'd5, 32'hFFFFFFFF, 1);
    issue("removf", i_rem, 32'h80000000, 32'hFFFFFFFF, 5'd6,
          32'd0, 1);
    issue("divovf", i_div, 32'h80000000, 32'hFFFFFFFF, 5'd4,
          32'h80000000, 1);
    issue("remu0", i_remu, 32'd55, 32'd0, 5'd7, 32'd55, 1);

    inst   = i_divu;
    op1    = 32'd1000;
    op2    = 32'd7;
    rd_in  = 5'd5;
    seen   = 0;
    hseen  = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (reg_wen_o) seen++;
      if (hold_o) hseen++;
      @(posedge clk);
    end
    #1;
    flush = 1'b1;
    @(negedge clk);
    if (reg_wen_o) seen++;
    chk("flush:pre_hold", 32'(hseen), 32'd11);
    chk("flush:hold", {31'd0, hold_o}, 32'd0);
    chk("flush:wen", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    issue("add_after_flush", i_add, 32'd40, 32'd2, 5'd3, 32'd42, 1);

    inst  = i_div;
    op1   = 32'd1234;
    op2   = 32'd10;
    rd_in = 5'd4;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    #1;
    chk("rstmid:data", rd_data_o, 32'd0);
    chk("rstmid:wen", {31'd0, reg_wen_o}, 32'd0);
    chk("rstmid:hold", {31'd0, hold_o}, 32'd0);
    chk("rstmid:addr", {27'd0, rd_addr_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    issue("div_after_rst", i_div, 32'd1234, -32'sd10, 5'd4,
          ref_md(3'd4, 32'd1234, -32'sd10), 34);

    issue("mulh", rtype(7'b0000001, 3'b001, 5'd13), 32'h80000000,
          32'd2, 5'd13, 32'hFFFFFFFF, MUL_LAT);
    issue("mul", rtype(7'b0000001, 3'b000, 5'd14), -32'sd3, 32'd7,
          5'd14, ref_md(3'd0, -32'sd3, 32'd7), MUL_LAT);
    issue("mulhsu", rtype(7'b0000001, 3'b010, 5'd15), -32'sd5,
          32'hF0000000, 5'd15, ref_md(3'd2, -32'sd5, 32'hF0000000),
          MUL_LAT);
    issue("mulhu", rtype(7'b0000001, 3'b011, 5'd16), 32'hDEADBEEF,
          32'hCAFEF00D, 5'd16, ref_md(3'd3, 32'hDEADBEEF, 32'hCAFEF00D),
          MUL_LAT);

    inst = rtype(7'b0100000, 3'b001, 5'd17);
    @(negedge clk);
    chk("illegal:wen", {31'd0, reg_wen_o}, 32'd0);
    chk("illegal:hold", {31'd0, hold_o}, 32'd0);
    @(posedge clk);
    #1;
    inst  = i_add;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idle:add_wen", {31'd0, reg_wen_o}, 32'd0);
    @(posedge clk);
    #1;
    inst = i_div;
    @(negedge clk);
    chk("flush_idle:div_hold", {31'd0, hold_o}, 32'd0);
    chk("flush_idle:div_wen", {31'd0, reg_wen_o}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    issue("add_after_idle_flush", i_add, 32'd7, 32'd8, 5'd3, 32'd15, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
